// File: rtl/filt_ppi_pkg.sv
// filt_ppi_pkg: shared types and helpers for the polyphase interpolator
package filt_ppi_pkg;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r < 1 ? 1 : r;
  endfunction
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc, input int shift, input int width);
    logic signed [63:0] r, hi, lo;
    r = (acc + (shift > 0 ? 64'sd1 <<< (shift - 1) : 64'sd0)) >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/filt_ppi_seq_mac.sv
// ppi_mac: shared multiply-accumulate with clear, enable and registered accumulator
module ppi_mac #(
  parameter int DW = 8,
  parameter int CW = 16,
  parameter int AW = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [CW-1:0] h_i,
  output logic signed [AW-1:0] acc_o,
  output logic signed [AW-1:0] sum_o
);
  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0] acc_q;
  assign prod = x_i * h_i;
  assign sum_o = acc_q + AW'(prod);
  assign acc_o = acc_q;
  // accumulate one tap per enabled cycle; clear wins so each phase starts at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) acc_q <= '0;
    else if (en_i) acc_q <= clr_i ? '0 : sum_o;
endmodule

// File: rtl/filt_ppi_seq.sv
// filt_ppi_seq: single-clock polyphase interpolation FIR with one shared MAC
module filt_ppi_seq
  import filt_ppi_pkg::*;
#(
  parameter int gp_idata_width  = 8,
  parameter int gp_coeff_width  = 16,
  parameter int gp_coeff_length = 53,
  parameter int gp_max_factor   = 8,
  parameter int gp_acc_width    = gp_idata_width + gp_coeff_width + $clog2(gp_coeff_length),
  parameter int gp_shift        = 0,
  parameter int gp_odata_width  = 24,
  localparam int FW  = clog2(gp_max_factor + 1),
  localparam int CAW = clog2(gp_coeff_length),
  localparam int PW  = clog2(gp_max_factor)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_ena,
  input  logic [FW-1:0]                    i_factor,
  input  logic                             i_flush,
  input  logic                             i_coeff_we,
  input  logic [CAW-1:0]                   i_coeff_addr,
  input  logic signed [gp_coeff_width-1:0] i_coeff_data,
  output logic                             o_coeff_drop,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic signed [gp_idata_width-1:0] i_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic signed [gp_odata_width-1:0] o_data,
  output logic [PW-1:0]                    o_phase
);
  localparam int N  = gp_coeff_length;
  localparam int KW = clog2(N);
  localparam int IW = clog2(N + gp_max_factor + 1);
  state_e state_q, state_d;
  logic signed [gp_idata_width-1:0] x_q [N];
  logic signed [gp_idata_width-1:0] x_d [N];
  logic signed [gp_coeff_width-1:0] h_q [N];
  logic signed [gp_coeff_width-1:0] h_d [N];
  logic [FW-1:0] l_q, l_d, l_eff;
  logic [PW-1:0] p_q, p_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [KW-1:0] k_q, k_d;
  logic signed [gp_odata_width-1:0] data_q, data_d;
  logic drop_q, drop_d;
  logic signed [gp_acc_width-1:0] acc, sum;
  logic signed [gp_coeff_width-1:0] h_sel;
  logic signed [63:0] rnd;
  logic last, coeff_ok;
  assign l_eff = i_factor == '0 ? FW'(1) : int'(i_factor) > gp_max_factor ? FW'(gp_max_factor) : i_factor;
  assign last = int'(idx_q) + int'(l_q) >= N;
  assign coeff_ok = state_q == IDLE && int'(i_coeff_addr) < N;
  assign h_sel = int'(idx_q) < N ? h_q[idx_q[CAW-1:0]] : '0;
  assign rnd = sat_round(64'(sum), gp_shift, gp_odata_width);
  assign o_ready = state_q == IDLE;
  assign o_valid = state_q == OUT;
  assign o_data = data_q;
  assign o_phase = p_q;
  assign o_coeff_drop = drop_q;
  ppi_mac #(.DW(gp_idata_width), .CW(gp_coeff_width), .AW(gp_acc_width)) u_mac (
    .clk(i_clk), .rst(i_rst), .en_i(i_ena), .clr_i(state_q != MAC),
    .x_i(x_q[k_q]), .h_i(h_sel), .acc_o(acc), .sum_o(sum)
  );
  // next state: accept in IDLE, walk one phase's taps in MAC, hold the result in OUT
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    h_d = h_q;
    l_d = l_q;
    p_d = p_q;
    idx_d = idx_q;
    k_d = k_q;
    data_d = data_q;
    drop_d = i_coeff_we && !coeff_ok;
    if (i_coeff_we && coeff_ok) h_d[i_coeff_addr] = i_coeff_data;
    unique case (state_q)
      IDLE: begin
        if (i_flush) for (int i = 0; i < N; i++) x_d[i] = '0;
        if (i_valid) begin
          for (int i = N - 1; i > 0; i--) x_d[i] = x_d[i-1];
          x_d[0] = i_data;
          l_d = l_eff;
          p_d = '0;
          idx_d = '0;
          k_d = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        idx_d = idx_q + IW'(l_q);
        k_d = k_q + KW'(1);
        if (last) begin
          state_d = OUT;
          data_d = rnd[gp_odata_width-1:0];
        end
      end
      OUT: if (i_ready) begin
        if (int'(p_q) == int'(l_q) - 1) state_d = IDLE;
        else begin
          p_d = p_q + PW'(1);
          idx_d = IW'(p_q) + IW'(1);
          k_d = '0;
          state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // FSM state register, frozen while disabled
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state_q <= IDLE;
    else if (i_ena) state_q <= state_d;
  // datapath registers: delay line, coefficients, phase counters and output hold
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      for (int i = 0; i < N; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
      end
      l_q <= FW'(1);
      p_q <= '0;
      idx_q <= '0;
      k_q <= '0;
      data_q <= '0;
      drop_q <= 1'b0;
    end else if (i_ena) begin
      x_q <= x_d;
      h_q <= h_d;
      l_q <= l_d;
      p_q <= p_d;
      idx_q <= idx_d;
      k_q <= k_d;
      data_q <= data_d;
      drop_q <= drop_d;
    end
endmodule

// File: tb/tb_filt_ppi_seq.sv
// tb_filt_ppi_seq: directed self-checking bench for filt_ppi_seq
module tb_filt_ppi_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic ena = 1'b1;
  logic [3:0] factor = 4'd4;
  logic flush = 1'b0, cwe = 1'b0, valid = 1'b0, iready = 1'b1;
  logic [2:0] caddr = '0;
  logic signed [15:0] cdata = '0;
  logic signed [7:0] din = '0;
  logic cdrop, oready, ovalid;
  logic signed [23:0] odata;
  logic [2:0] ophase;
  logic s_flush = 1'b0, s_cwe = 1'b0, s_valid = 1'b0;
  logic [2:0] s_caddr = '0;
  logic signed [15:0] s_cdata = '0;
  logic signed [7:0] s_din = '0;
  logic s_cdrop, s_oready, s_ovalid;
  logic signed [7:0] s_odata;
  logic [2:0] s_ophase;
  int pass_cnt = 0;
  int total_cnt = 0;

  filt_ppi_seq #(.gp_coeff_length(8), .gp_odata_width(24)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_factor(factor), .i_flush(flush),
    .i_coeff_we(cwe), .i_coeff_addr(caddr), .i_coeff_data(cdata), .o_coeff_drop(cdrop),
    .i_valid(valid), .o_ready(oready), .i_data(din), .o_valid(ovalid), .i_ready(iready),
    .o_data(odata), .o_phase(ophase)
  );

  filt_ppi_seq #(.gp_coeff_length(8), .gp_odata_width(8), .gp_shift(1)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_ena(1'b1), .i_factor(4'd1), .i_flush(s_flush),
    .i_coeff_we(s_cwe), .i_coeff_addr(s_caddr), .i_coeff_data(s_cdata), .o_coeff_drop(s_cdrop),
    .i_valid(s_valid), .o_ready(s_oready), .i_data(s_din), .o_valid(s_ovalid), .i_ready(1'b1),
    .o_data(s_odata), .o_phase(s_ophase)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wcoef(input int a, input int d);
    cwe = 1'b1;
    caddr = 3'(a);
    cdata = 16'(d);
    tick();
    cwe = 1'b0;
  endtask

  task automatic push(input int d, input bit fl);
    valid = 1'b1;
    din = 8'(d);
    flush = fl;
    tick();
    valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!ovalid && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!ovalid) cyc = -1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total_cnt++; if (oready !== 1'b1) $display("FAIL reset o_ready: got %b expected 1", oready); else pass_cnt++;
    total_cnt++; if (ovalid !== 1'b0) $display("FAIL reset o_valid: got %b expected 0", ovalid); else pass_cnt++;
    total_cnt++; if (odata !== 24'sd0) $display("FAIL reset o_data: got %0d expected 0", odata); else pass_cnt++;
    total_cnt++; if (ophase !== 3'd0) $display("FAIL reset o_phase: got %0d expected 0", ophase); else pass_cnt++;
    total_cnt++; if (cdrop !== 1'b0) $display("FAIL reset o_coeff_drop: got %b expected 0", cdrop); else pass_cnt++;
    total_cnt++; if (s_ovalid !== 1'b0 || s_oready !== 1'b1) $display("FAIL reset sat handshake: got v%b r%b expected v0 r1", s_ovalid, s_oready); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_impulse();
    int cyc;
    factor = 4'd4;
    for (int i = 0; i < 8; i++) wcoef(i, i + 1);
    for (int s = 0; s < 2; s++) begin
      push(s == 0 ? 1 : 0, 1'b0);
      for (int p = 0; p < 4; p++) begin
        wait_out(cyc);
        total_cnt++; if (cyc !== 2) $display("FAIL impulse gap s%0d p%0d: got %0d expected 2", s, p, cyc); else pass_cnt++;
        total_cnt++; if (odata !== 24'(s * 4 + p + 1)) $display("FAIL impulse data s%0d p%0d: got %0d expected %0d", s, p, odata, s * 4 + p + 1); else pass_cnt++;
        total_cnt++; if (ophase !== 3'(p)) $display("FAIL impulse phase s%0d: got %0d expected %0d", s, ophase, p); else pass_cnt++;
        total_cnt++; if (oready !== 1'b0) $display("FAIL impulse o_ready s%0d p%0d: got %b expected 0", s, p, oready); else pass_cnt++;
        tick();
      end
    end
  endtask

  task automatic test_l1();
    int cyc;
    factor = 4'd1;
    for (int i = 0; i < 8; i++) wcoef(i, 1);
    for (int n = 1; n <= 10; n++) begin
      push(1, n == 1);
      wait_out(cyc);
      total_cnt++; if (cyc !== 8) $display("FAIL l1 latency n%0d: got %0d expected 8", n, cyc); else pass_cnt++;
      total_cnt++; if (odata !== 24'(n > 8 ? 8 : n)) $display("FAIL l1 data n%0d: got %0d expected %0d", n, odata, n > 8 ? 8 : n); else pass_cnt++;
      tick();
      total_cnt++; if (oready !== 1'b1) $display("FAIL l1 single output n%0d: o_ready %b expected 1", n, oready); else pass_cnt++;
    end
    factor = 4'd0;
    for (int n = 1; n <= 3; n++) begin
      push(1, n == 1);
      wait_out(cyc);
      total_cnt++; if (cyc !== 8 || ophase !== 3'd0) $display("FAIL l0 timing n%0d: got cyc %0d phase %0d expected 8 and 0", n, cyc, ophase); else pass_cnt++;
      total_cnt++; if (odata !== 24'(n)) $display("FAIL l0 data n%0d: got %0d expected %0d", n, odata, n); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_sat();
    int hv [5] = '{127, 127, 1, 1, 1};
    int xv [5] = '{127, -128, 3, -3, 5};
    bit fv [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int ev [5] = '{127, -128, 2, -1, 3};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      s_cwe = 1'b1;
      s_caddr = '0;
      s_cdata = 16'(hv[i]);
      tick();
      s_cwe = 1'b0;
      s_valid = 1'b1;
      s_din = 8'(xv[i]);
      s_flush = fv[i];
      tick();
      s_valid = 1'b0;
      s_flush = 1'b0;
      cyc = 0;
      while (!s_ovalid && cyc < 50) begin
        tick();
        cyc++;
      end
      total_cnt++; if (!s_ovalid || s_odata !== 8'(ev[i])) $display("FAIL sat case %0d: got valid %b data %0d expected %0d", i, s_ovalid, s_odata, ev[i]); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    factor = 4'd4;
    for (int i = 0; i < 8; i++) wcoef(i, i + 1);
    push(1, 1'b1);
    for (int p = 0; p < 2; p++) begin
      wait_out(cyc);
      total_cnt++; if (odata !== 24'(p + 1)) $display("FAIL bp pre data p%0d: got %0d expected %0d", p, odata, p + 1); else pass_cnt++;
      tick();
    end
    wait_out(cyc);
    iready = 1'b0;
    valid = 1'b1;
    din = 8'sd9;
    for (int c = 0; c < 5; c++) begin
      tick();
      total_cnt++; if (ovalid !== 1'b1 || ophase !== 3'd2) $display("FAIL bp hold c%0d: got valid %b phase %0d expected 1 and 2", c, ovalid, ophase); else pass_cnt++;
      total_cnt++; if (odata !== 24'sd3) $display("FAIL bp data c%0d: got %0d expected 3", c, odata); else pass_cnt++;
      total_cnt++; if (oready !== 1'b0) $display("FAIL bp o_ready c%0d: got %b expected 0", c, oready); else pass_cnt++;
    end
    valid = 1'b0;
    iready = 1'b1;
    tick();
    wait_out(cyc);
    total_cnt++; if (ophase !== 3'd3 || odata !== 24'sd4) $display("FAIL bp phase3: got phase %0d data %0d expected 3 and 4", ophase, odata); else pass_cnt++;
    tick();
    push(0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      wait_out(cyc);
      total_cnt++; if (odata !== 24'(p + 5)) $display("FAIL bp no-extra-accept p%0d: got %0d expected %0d", p, odata, p + 5); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_coeff_flush();
    int cyc;
    wcoef(3, 4);
    total_cnt++; if (cdrop !== 1'b0) $display("FAIL coeff idle write drop: got %b expected 0", cdrop); else pass_cnt++;
    push(5, 1'b1);
    cwe = 1'b1;
    caddr = 3'd0;
    cdata = 16'sd99;
    tick();
    cwe = 1'b0;
    total_cnt++; if (cdrop !== 1'b1) $display("FAIL coeff drop pulse: got %b expected 1", cdrop); else pass_cnt++;
    tick();
    total_cnt++; if (cdrop !== 1'b0) $display("FAIL coeff drop width: got %b expected 0", cdrop); else pass_cnt++;
    for (int s = 0; s < 2; s++) begin
      if (s == 1) push(0, 1'b0);
      for (int p = 0; p < 4; p++) begin
        wait_out(cyc);
        total_cnt++; if (odata !== 24'(5 * (s * 4 + p + 1))) $display("FAIL flush data s%0d p%0d: got %0d expected %0d", s, p, odata, 5 * (s * 4 + p + 1)); else pass_cnt++;
        tick();
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    push(7, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    total_cnt++; if (ovalid !== 1'b0 || oready !== 1'b1) $display("FAIL midreset handshake: got v%b r%b expected v0 r1", ovalid, oready); else pass_cnt++;
    total_cnt++; if (odata !== 24'sd0) $display("FAIL midreset data: got %0d expected 0", odata); else pass_cnt++;
    rst = 1'b0;
    tick();
    factor = 4'd4;
    for (int i = 0; i < 8; i++) wcoef(i, i + 1);
    for (int s = 0; s < 2; s++) begin
      push(s == 0 ? 1 : 0, 1'b0);
      for (int p = 0; p < 4; p++) begin
        wait_out(cyc);
        total_cnt++; if (odata !== 24'(s * 4 + p + 1)) $display("FAIL midreset line s%0d p%0d: got %0d expected %0d", s, p, odata, s * 4 + p + 1); else pass_cnt++;
        if (s == 0 && p == 1) begin
          ena = 1'b0;
          for (int c = 0; c < 3; c++) begin
            tick();
            total_cnt++; if (ovalid !== 1'b1 || ophase !== 3'd1 || odata !== 24'sd2) $display("FAIL enable freeze c%0d: got v%b phase %0d data %0d expected 1,1,2", c, ovalid, ophase, odata); else pass_cnt++;
          end
          ena = 1'b1;
        end
        tick();
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_l1();
    test_sat();
    test_backpressure();
    test_coeff_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
